// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request channel for the fetch unit.
//   imem_req   : fetch request valid (fetch unit -> memory)
//   imem_addr  : word-aligned fetch byte address (fetch unit -> memory)
//   imem_ready : memory accepts request, imem_rdata valid same cycle
//   imem_rdata : instruction word (memory -> fetch unit)
// master = fetch unit side, slave = memory side.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ready, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Issues word-aligned requests over a req/ready channel, buffers one word
// while decode stalls, and applies MEM-stage redirects with flush.
// Ports:
//   Clk, Rst        : clock (rising edge), async active-high reset
//   imem            : instruction-memory channel (master side)
//   id_stall        : ID stage cannot accept; hold IF/ID outputs
//   redirect_valid  : taken branch/jump/jr this cycle
//   redirect_target : new PC (low two bits ignored)
//   id_valid/id_instr/id_pc4 : IF/ID register outputs
//   fetch_pc        : current fetch PC (debug)
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic            Clk,
  input  logic            Rst,
  if_fetch_unit_if.master imem,
  input  logic            id_stall,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_target,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [31:0]     id_pc4,
  output logic [31:0]     fetch_pc
);

  typedef enum logic {FETCH, DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        accept;
  logic [31:0] target_al;

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
      buf_valid_q   <= 1'b0;
      buf_instr_q   <= '0;
      buf_pc4_q     <= '0;
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP_INSTR;
      id_pc4_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      buf_valid_q   <= buf_valid_d;
      buf_instr_q   <= buf_instr_d;
      buf_pc4_q     <= buf_pc4_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc4_q      <= id_pc4_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    buf_valid_d   = buf_valid_q;
    buf_instr_d   = buf_instr_q;
    buf_pc4_d     = buf_pc4_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc4_d      = id_pc4_q;

    accept    = imem.imem_req && imem.imem_ready;
    target_al = redirect_target & ~32'd3;

    // PC / FSM. pc_q keeps the abandoned address throughout DISCARD so the
    // outstanding request stays stable until the memory takes it.
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          if (imem.imem_req && !imem.imem_ready) begin
            pend_target_d = target_al;
            state_d       = DISCARD;
          end else begin
            pc_d = target_al;
          end
        end else if (accept) begin
          pc_d = pc_q + 32'd4;
        end
      end
      DISCARD: begin
        if (redirect_valid) pend_target_d = target_al;
        if (imem.imem_ready) begin
          pc_d    = redirect_valid ? target_al : pend_target_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // IF/ID registers and skid buffer; only FETCH-state accepts carry data.
    if (redirect_valid) begin
      id_valid_d  = 1'b0;
      id_instr_d  = NOP_INSTR;
      buf_valid_d = 1'b0;
    end else if (!id_stall) begin
      if (buf_valid_q) begin
        id_valid_d  = 1'b1;
        id_instr_d  = buf_instr_q;
        id_pc4_d    = buf_pc4_q;
        buf_valid_d = 1'b0;
      end else if (accept && state_q == FETCH) begin
        id_valid_d = 1'b1;
        id_instr_d = imem.imem_rdata;
        id_pc4_d   = pc_q + 32'd4;
      end else begin
        id_valid_d = 1'b0;
      end
    end else if (accept && state_q == FETCH) begin
      buf_valid_d = 1'b1;
      buf_instr_d = imem.imem_rdata;
      buf_pc4_d   = pc_q + 32'd4;
    end
  end

  // Output logic
  always_comb begin
    imem.imem_addr = pc_q;
    if (Rst)                     imem.imem_req = 1'b0;
    else if (state_q == DISCARD) imem.imem_req = 1'b1;
    else                         imem.imem_req = !buf_valid_q;
  end

  assign id_valid = id_valid_q;
  assign id_instr = id_instr_q;
  assign id_pc4   = id_pc4_q;
  assign fetch_pc = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, hand-written
// wrap / reset sequences, and randomized traffic against a queue-based model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        Clk;
  logic        Rst;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [31:0] fetch_pc;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .imem            (bus),
    .id_stall        (id_stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc4          (id_pc4),
    .fetch_pc        (fetch_pc)
  );

  // Address-dependent memory contents; low bits 11 keep words distinct from NOP.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2] ^ 30'h2AAA_5555, 2'b11};
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rdy, input bit stl, input bit rdr, input logic [31:0] tgt);
    bus.imem_ready  = rdy;
    id_stall        = stl;
    redirect_valid  = rdr;
    redirect_target = tgt;
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Reset state is checked while Rst is held; returns at a negedge after release.
  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0);
    Rst = 1'b1;
    #1;
    chk("rst_req",      {31'd0, bus.imem_req}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid},     32'd0);
    chk("rst_id_instr", id_instr,              NOP);
    chk("rst_id_pc4",   id_pc4,                32'd0);
    chk("rst_fetch_pc", fetch_pc,              32'd0);
    next_cycle();
    Rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_pend, m_instr, m_pc4;
  bit          m_disc, m_vld;

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0; m_pend = 32'h0; m_instr = NOP; m_pc4 = 32'h0;
    m_disc = 1'b0; m_vld = 1'b0;
  endtask

  function automatic bit model_req();
    return m_disc || (mq.size() == 0);
  endfunction

  task automatic model_step(input bit rdy, input bit stl, input bit rdr, input logic [31:0] tgt);
    logic [31:0] t;
    bit          req;
    ent_t        e;
    t   = {tgt[31:2], 2'b00};
    req = model_req();
    if (rdr) begin
      m_vld = 1'b0;
      m_instr = NOP;
      mq.delete();
      if (m_disc) begin
        if (rdy) begin m_pc = t; m_disc = 1'b0; end
        else m_pend = t;
      end else if (req && !rdy) begin
        m_disc = 1'b1;
        m_pend = t;
      end else begin
        m_pc = t;
      end
    end else begin
      if (req && rdy) begin
        if (m_disc) begin
          m_pc = m_pend;
          m_disc = 1'b0;
        end else begin
          e.instr = mem_word(m_pc);
          e.pc4   = m_pc + 32'd4;
          mq.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
      if (!stl) begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          m_vld = 1'b1; m_instr = e.instr; m_pc4 = e.pc4;
        end else begin
          m_vld = 1'b0;
        end
      end
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          rdy, stl, rdr;
    logic [31:0] tgt;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_vld;
    logic [31:0] e_pc4;
    bit          e_nop;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input bit rdy, input bit stl, input bit rdr, input logic [31:0] tgt,
                              input bit req, input logic [31:0] addr, input bit vld,
                              input logic [31:0] pc4, input bit nop);
    vec_t v;
    v.rdy = rdy; v.stl = stl; v.rdr = rdr; v.tgt = tgt;
    v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.e_pc4 = pc4; v.e_nop = nop;
    return v;
  endfunction

  initial begin
    //             rdy stl rdr tgt          req addr         vld pc4          nop
    vecs[0]  = mk(1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0);
    vecs[1]  = mk(1, 0, 0, 32'h0,        1, 32'h4,        1, 32'h4,        0);
    vecs[2]  = mk(1, 1, 0, 32'h0,        1, 32'h8,        1, 32'h8,        0);
    vecs[3]  = mk(1, 1, 0, 32'h0,        0, 32'hC,        1, 32'h8,        0);
    vecs[4]  = mk(1, 1, 0, 32'h0,        0, 32'hC,        1, 32'h8,        0);
    vecs[5]  = mk(1, 0, 0, 32'h0,        0, 32'hC,        1, 32'h8,        0);
    vecs[6]  = mk(1, 0, 0, 32'h0,        1, 32'hC,        1, 32'hC,        0);
    vecs[7]  = mk(0, 0, 0, 32'h0,        1, 32'h10,       1, 32'h10,       0);
    vecs[8]  = mk(0, 0, 0, 32'h0,        1, 32'h10,       0, 32'h0,        0);
    vecs[9]  = mk(1, 0, 0, 32'h0,        1, 32'h10,       0, 32'h0,        0);
    vecs[10] = mk(0, 0, 0, 32'h0,        1, 32'h14,       1, 32'h14,       0);
    vecs[11] = mk(0, 0, 0, 32'h0,        1, 32'h14,       0, 32'h0,        0);
    vecs[12] = mk(1, 0, 0, 32'h0,        1, 32'h14,       0, 32'h0,        0);
    vecs[13] = mk(1, 0, 1, 32'h42,       1, 32'h18,       1, 32'h18,       0);
    vecs[14] = mk(1, 0, 0, 32'h0,        1, 32'h40,       0, 32'h0,        1);
    vecs[15] = mk(0, 0, 1, 32'h100,      1, 32'h44,       1, 32'h44,       0);
    vecs[16] = mk(0, 0, 1, 32'h200,      1, 32'h44,       0, 32'h0,        1);
    vecs[17] = mk(1, 0, 0, 32'h0,        1, 32'h44,       0, 32'h0,        1);
    vecs[18] = mk(1, 0, 0, 32'h0,        1, 32'h200,      0, 32'h0,        1);
    vecs[19] = mk(1, 0, 0, 32'h0,        1, 32'h204,      1, 32'h204,      0);
  end

  // ---------------- main sequence ----------------
  initial begin
    bit          r_rdy, r_stl, r_rdr;
    logic [31:0] r_tgt;

    Rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    @(negedge Clk);

    // Directed table
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rdy, vecs[i].stl, vecs[i].rdr, vecs[i].tgt);
      #1;
      chk($sformatf("vec%0d_req", i),  {31'd0, bus.imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("vec%0d_addr", i), bus.imem_addr,         vecs[i].e_addr);
      chk($sformatf("vec%0d_vld", i),  {31'd0, id_valid},     {31'd0, vecs[i].e_vld});
      if (vecs[i].e_vld) begin
        chk($sformatf("vec%0d_pc4", i),   id_pc4,   vecs[i].e_pc4);
        chk($sformatf("vec%0d_instr", i), id_instr, mem_word(vecs[i].e_pc4 - 32'd4));
      end
      if (vecs[i].e_nop) chk($sformatf("vec%0d_nop", i), id_instr, NOP);
      next_cycle();
    end

    // PC wrap: redirect to the last word (misaligned target gets aligned)
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0);
    #1;
    chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    #1;
    chk("wrap_addr1",  bus.imem_addr,       32'h0);
    chk("wrap_vld",    {31'd0, id_valid},   32'd1);
    chk("wrap_pc4",    id_pc4,              32'h0);
    chk("wrap_instr",  id_instr,            mem_word(32'hFFFF_FFFC));
    next_cycle();

    // Reset asserted mid-stall with the buffer full
    do_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, '0);
    next_cycle();
    #1;
    chk("stall_req_off", {31'd0, bus.imem_req}, 32'd0);
    chk("stall_hold",    id_pc4,                32'h4);
    #1;
    Rst = 1'b1;
    #1;
    chk("async_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("async_vld",   {31'd0, id_valid},     32'd0);
    chk("async_instr", id_instr,              NOP);
    chk("async_pc4",   id_pc4,                32'd0);
    chk("async_pc",    fetch_pc,              32'd0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, '0);
    Rst = 1'b0;
    #1;
    chk("post_rst_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("post_rst_addr", bus.imem_addr,         32'd0);
    next_cycle();

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      r_rdy = ($urandom_range(0, 9) < 7);
      r_stl = ($urandom_range(0, 9) < 3);
      r_rdr = ($urandom_range(0, 99) < 8);
      r_tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                          : ($urandom & 32'h0000_0FFF);
      drive(r_rdy, r_stl, r_rdr, r_tgt);
      #1;
      chk("rnd_req",   {31'd0, bus.imem_req}, {31'd0, model_req()});
      chk("rnd_addr",  bus.imem_addr,         m_pc);
      chk("rnd_vld",   {31'd0, id_valid},     {31'd0, m_vld});
      chk("rnd_instr", id_instr,              m_instr);
      chk("rnd_pc4",   id_pc4,                m_pc4);
      chk("rnd_pc",    fetch_pc,              m_pc);
      model_step(r_rdy, r_stl, r_rdr, r_tgt);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
